// File: rtl/exp_table_store.sv
// Captures the streamed exp-sigma table into block RAM, sums all entries once
// the generator finishes, then serves single-cycle-latency random lookups.
`timescale 1ns/1ps
module exp_table_store #(
    parameter int DATA_W = 18,
    parameter int ADDR_W = 10,
    parameter int SUM_W  = 28
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              iStart,
    input  logic              iWe,
    input  logic [DATA_W-1:0] iData,
    input  logic [ADDR_W-1:0] iAddr,
    input  logic              iDone,
    input  logic              iReqValid,
    input  logic [ADDR_W-1:0] iReqAddr,
    output logic              oReqReady,
    output logic              oRespValid,
    output logic [DATA_W-1:0] oRespData,
    output logic [SUM_W-1:0]  oSum,
    output logic              oReady
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] SUM   = 2'd2;
    localparam logic [1:0] READY = 2'd3;

    logic [1:0]        state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ramQ;
    logic [DATA_W-1:0] respHold;
    logic [ADDR_W-1:0] rdCnt;
    logic [ADDR_W-1:0] ramAddr;
    logic [SUM_W-1:0]  acc;
    logic              readsDone;
    logic              accValid;
    logic              respValid;
    logic              ramWe;
    logic              ramRe;
    logic              reqFire;

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        ramWe   = (state == FILL) && iWe;
        reqFire = (state == READY) && iReqValid && !iStart;
        ramRe   = ((state == SUM) && !readsDone && !iStart) || reqFire;
        ramAddr = iReqAddr;
        case (state)
            FILL:    ramAddr = iAddr;
            SUM:     ramAddr = rdCnt;
            default: ;
        endcase
    end

    // NOTE: the RAM array and its read register carry no reset so the tools can map them to block RAM.
    always_ff @(posedge CLK) begin
        if (ramWe) mem[ramAddr] <= iData;
        if (ramRe) ramQ <= mem[ramAddr];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            rdCnt     <= '0;
            readsDone <= 1'b0;
            accValid  <= 1'b0;
            acc       <= '0;
            oSum      <= '0;
            oReady    <= 1'b0;
            respValid <= 1'b0;
            respHold  <= '0;
        end else begin
            respValid <= reqFire;
            if (respValid) respHold <= ramQ;
            if (iStart) begin
                state     <= FILL;
                rdCnt     <= '0;
                readsDone <= 1'b0;
                accValid  <= 1'b0;
                acc       <= '0;
                oSum      <= '0;
                oReady    <= 1'b0;
            end else begin
                case (state)
                    FILL: if (iDone) state <= SUM;
                    SUM: begin
                        // Read result lands one cycle after issue, so accumulation trails the counter.
                        accValid <= !readsDone;
                        if (!readsDone) begin
                            rdCnt <= rdCnt + 1'b1;
                            if (rdCnt == {ADDR_W{1'b1}}) readsDone <= 1'b1;
                        end
                        if (accValid) acc <= acc + SUM_W'(ramQ);
                        if (accValid && readsDone) begin
                            oSum   <= acc + SUM_W'(ramQ);
                            oReady <= 1'b1;
                            state  <= READY;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // The RAM register is shared with SUM reads, so a held copy keeps oRespData stable between responses.
    assign oReqReady  = (state == READY);
    assign oRespValid = respValid;
    assign oRespData  = respValid ? ramQ : respHold;
endmodule

// File: tb/tb_exp_table_store.sv
// Scoreboard bench for exp_table_store: directed fills with hand-computed sums,
// lookups checked by an independent monitor popping an expected-response queue.
`timescale 1ns/1ps
module tb_exp_table_store;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        iStart = 1'b0;
    logic        iWe = 1'b0;
    logic [17:0] iData = '0;
    logic [9:0]  iAddr = '0;
    logic        iDone = 1'b0;
    logic        iReqValid = 1'b0;
    logic [9:0]  iReqAddr = '0;
    logic        oReqReady;
    logic        oRespValid;
    logic [17:0] oRespData;
    logic [27:0] oSum;
    logic        oReady;

    int nCompared = 0;
    int nMismatched = 0;
    int runLen = 0;
    int lastRun = 0;
    logic [17:0] expQ[$];

    exp_table_store dut (
        .CLK(CLK), .RST_N(RST_N), .iStart(iStart), .iWe(iWe), .iData(iData),
        .iAddr(iAddr), .iDone(iDone), .iReqValid(iReqValid), .iReqAddr(iReqAddr),
        .oReqReady(oReqReady), .oRespValid(oRespValid), .oRespData(oRespData),
        .oSum(oSum), .oReady(oReady)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every response pulse must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (oRespValid === 1'b1) begin
            runLen++;
            if (expQ.size() == 0) check("resp_unexpected", {31'b0, oRespValid}, 32'd0);
            else check("resp_data", {14'b0, oRespData}, {14'b0, expQ.pop_front()});
        end else if (runLen > 0) begin
            lastRun = runLen;
            runLen  = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // mode 0: data = addr, 1: all 0x3FFFF, 2: data = 2*addr
    task automatic fill(input int mode, input bit doneWithLast, input bit reqNoise);
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            iWe       = 1'b1;
            iAddr     = 10'(i);
            iData     = (mode == 0) ? 18'(i) : (mode == 1) ? 18'h3FFFF : 18'(2 * i);
            iReqValid = reqNoise;
            iReqAddr  = 10'(i);
            iDone     = doneWithLast && (i == 1023);
            tick();
            if (reqNoise && i == 512) check("fill_reqready_low", {31'b0, oReqReady}, 32'd0);
        end
        iWe       = 1'b0;
        iReqValid = 1'b0;
        if (!doneWithLast) begin
            iDone = 1'b1;
            tick();
        end
        iDone = 1'b0;
    endtask

    task automatic waitReady(input string name, input logic [27:0] expSum, input bit reqNoise);
        int n = 0;
        while (oReady !== 1'b1 && n < 2000) begin
            iReqValid = reqNoise && (n < 100);
            iReqAddr  = 10'd700;
            tick();
            n++;
            if (reqNoise && n == 50) begin
                check("sum_reqready_low", {31'b0, oReqReady}, 32'd0);
                check("sum_osum_zero", {4'b0, oSum}, 32'd0);
            end
        end
        iReqValid = 1'b0;
        check({name, "_latency"}, n, 32'd1025);
        check({name, "_sum"}, {4'b0, oSum}, {4'b0, expSum});
        check({name, "_reqready"}, {31'b0, oReqReady}, 32'd1);
    endtask

    task automatic lookup(input logic [9:0] addr, input logic [17:0] expData);
        expQ.push_back(expData);
        iReqValid = 1'b1;
        iReqAddr  = addr;
        tick();
    endtask

    initial begin
        repeat (3) tick();
        check("rst_reqready", {31'b0, oReqReady}, 32'd0);
        check("rst_respvalid", {31'b0, oRespValid}, 32'd0);
        check("rst_ready", {31'b0, oReady}, 32'd0);
        check("rst_sum", {4'b0, oSum}, 32'd0);
        check("rst_respdata", {14'b0, oRespData}, 32'd0);
        RST_N = 1'b1;
        tick();

        // Ramp fill then back-to-back lookups.
        fill(0, 1'b0, 1'b0);
        waitReady("ramp", 28'd523776, 1'b0);
        lookup(10'd5, 18'd5);
        lookup(10'd1023, 18'd1023);
        lookup(10'd0, 18'd0);
        iReqValid = 1'b0;
        repeat (3) tick();
        check("b2b_run_length", lastRun, 32'd3);

        // Max values, with requests asserted during FILL and SUM.
        fill(1, 1'b0, 1'b1);
        waitReady("max", 28'd268434432, 1'b1);
        lookup(10'd700, 18'h3FFFF);
        iReqValid = 1'b0;
        repeat (3) tick();
        check("hold_respvalid", {31'b0, oRespValid}, 32'd0);
        check("hold_respdata", {14'b0, oRespData}, 32'h3FFFF);

        // Reset mid-SUM.
        fill(0, 1'b0, 1'b0);
        repeat (500) tick();
        RST_N = 1'b0;
        #1;
        check("midsum_rst_ready", {31'b0, oReady}, 32'd0);
        check("midsum_rst_sum", {4'b0, oSum}, 32'd0);
        check("midsum_rst_respdata", {14'b0, oRespData}, 32'd0);
        check("midsum_rst_reqready", {31'b0, oReqReady}, 32'd0);
        tick();
        RST_N = 1'b1;
        iDone = 1'b1;
        tick();
        iDone = 1'b0;
        repeat (1100) tick();
        check("idle_done_ignored", {31'b0, oReady}, 32'd0);
        fill(0, 1'b0, 1'b0);
        waitReady("refill", 28'd523776, 1'b0);

        // Restart while READY, colliding with an accepted request.
        iStart    = 1'b1;
        iReqValid = 1'b1;
        iReqAddr  = 10'd9;
        tick();
        iStart    = 1'b0;
        iReqValid = 1'b0;
        check("restart_ready", {31'b0, oReady}, 32'd0);
        check("restart_sum", {4'b0, oSum}, 32'd0);
        check("restart_respvalid", {31'b0, oRespValid}, 32'd0);
        check("restart_reqready", {31'b0, oReqReady}, 32'd0);
        tick();

        // Doubled ramp, last write coinciding with iDone.
        fill(2, 1'b1, 1'b0);
        waitReady("double", 28'd1047552, 1'b0);
        lookup(10'd1023, 18'd2046);
        iReqValid = 1'b0;
        repeat (3) tick();
        check("queue_drained", expQ.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
